hrm_mem_arbiter: RTL and testbench
==================================

Name: hrm_mem_arbiter

Overview:
- Shares the single-port synchronous data RAM (1-cycle read latency) between two requesters: the CPU datapath (driven by the control unit's memory strobes) and a host/debug port (UART loader and inspector).
- Round-robin arbitration with one grant per cycle.
- Host lock mode freezes CPU memory traffic for coherent dump/load.
- Saturating CPU stall counter for debug visibility.

Parameters:
- AW, 5, RAM address width (32 cells).
- DW, 8, data width.
- STALL_W, 16, width of the CPU stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1=write, 0=read; stable while cpu_req.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  access accepted this cycle (combinational).
- cpu_rvalid  out  1  read data valid (registered).
- cpu_rdata  out  DW  read data.
- host_req, host_we, host_addr, host_wdata  in  1/1/AW/DW  host request bundle, same rules as CPU.
- host_gnt, host_rvalid, host_rdata  out  1/1/DW  host response, same rules as CPU.
- host_lock  in  1  level; request exclusive access for host.
- locked  out  1  CPU fully excluded.
- stall_cnt  out  STALL_W  cycles with cpu_req=1 and cpu_gnt=0, saturating.
- mem_en, mem_we  out  1/1  RAM enable and write strobe.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (async, i_rst=1):
  - Registered outputs: cpu_rvalid=0, host_rvalid=0, locked=0, stall_cnt=0.
  - Lock FSM=UNLOCKED; rr_last=HOST, so CPU wins the first tie.
  - Combinational outputs while in reset: cpu_gnt=0, host_gnt=0, mem_en=0, mem_we=0.
- Grant logic (combinational, one grant per cycle):
  - cpu_eligible = cpu_req & (lock state != LOCKED).
  - Only one eligible requester: it is granted.
  - Both eligible: grant the port that is not rr_last.
  - rr_last updates on every grant to the granted port.
- Granted cycle: mem_en=1; mem_we, mem_addr and mem_wdata come from the granted port.
  - No grant: mem_en=0, mem_we=0, mem_addr/mem_wdata hold the CPU values (don't-care).
- Read return:
  - x_rvalid registers (x_gnt & ~x_we); it is high exactly one cycle after the grant.
  - cpu_rdata and host_rdata are both mem_rdata; x_rvalid qualifies them.
  - Back-to-back reads on alternating ports are allowed; each rvalid follows its own grant.
- Write: completes in the grant cycle; no response strobe.
- Requester rule: it may deassert req or change the bundle only in the cycle after gnt. Consecutive grants to the same port are allowed if the other port is idle.
- Lock FSM (states UNLOCKED, PENDING, LOCKED):
  - UNLOCKED -> PENDING when host_lock=1.
  - PENDING: CPU still arbitrated normally; -> LOCKED when no CPU grant occurs this cycle and cpu_rvalid=0.
  - PENDING -> UNLOCKED if host_lock drops first.
  - LOCKED: cpu_gnt forced 0; locked=1 (registered, equals state==LOCKED).
  - LOCKED -> UNLOCKED the cycle after host_lock=0; CPU may be granted in that UNLOCKED cycle.
  - The host is arbitrated in all states.
- Stall counter:
  - Increments when cpu_req=1 and cpu_gnt=0.
  - Saturates at all-ones; never wraps.
  - Cleared only by reset.
- Reset mid-operation: a pending rvalid is dropped; the requester restarts.
- Unknown lock state encoding: recover to UNLOCKED.

Test Plan:
- CPU-only read: mem pre-loaded addr 5=0x2A; cpu_req read addr 5 -> cpu_gnt same cycle, cpu_rvalid next cycle with cpu_rdata=0x2A; host_rvalid stays 0.
- Simultaneous reads: CPU addr 1=0x11, host addr 2=0x22, both held for 4 cycles -> grants CPU, HOST, CPU, HOST; rvalids alternate with 0x11/0x22.
- Write then read: host writes 0x7F to addr 31, then CPU reads addr 31 -> cpu_rdata=0x7F; mem_we=1 only in the host grant cycle.
- Lock: CPU read streaming, raise host_lock -> the last CPU rvalid completes, then locked=1 and cpu_gnt=0. Host write of 0x55 to addr 3 is granted. Drop host_lock -> locked=0 next cycle and the CPU is granted again; stall_cnt equals the cycles stalled.
- Stall saturation: STALL_W=4, cpu_req held while locked for 20 cycles -> stall_cnt stops at 15.
- Async reset mid-read: assert i_rst between grant and rvalid -> all rvalid=0, locked=0, stall_cnt=0 immediately; after release, CPU wins the first tie.

Source files
------------

// File: rtl/hrm_mem_arbiter.sv
// hrm_mem_arbiter
//   Shares a single-port synchronous RAM (1-cycle read latency) between the
//   CPU datapath and the host/debug port. Round-robin, one grant per cycle.
//   The host can request exclusive access (host_lock) for coherent dump/load.
//   A saturating counter records the cycles in which the CPU was kept waiting.
//
// Ports
//   clk, i_rst                     clock, async active-high reset
//   cpu_req/we/addr/wdata          CPU request bundle (held until cpu_gnt)
//   cpu_gnt/rvalid/rdata           CPU response (gnt combinational)
//   host_req/we/addr/wdata         host request bundle
//   host_gnt/rvalid/rdata          host response
//   host_lock, locked              exclusive-access request / CPU excluded
//   stall_cnt                      saturating CPU stall cycle count
//   mem_en/we/addr/wdata, mem_rdata  RAM port
module hrm_mem_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_wdata,
  output logic               cpu_gnt,
  output logic               cpu_rvalid,
  output logic [DW-1:0]      cpu_rdata,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [AW-1:0]      host_addr,
  input  logic [DW-1:0]      host_wdata,
  output logic               host_gnt,
  output logic               host_rvalid,
  output logic [DW-1:0]      host_rdata,
  input  logic               host_lock,
  output logic               locked,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_PENDING  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam logic RR_CPU  = 1'b0;
  localparam logic RR_HOST = 1'b1;

  logic [1:0]         state_q, state_d;
  logic               rr_last_q, rr_last_d;
  logic               locked_q;
  logic               cpu_rvalid_q, host_rvalid_q;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               cpu_elig, host_elig;

  // Grants are gated by reset so nothing reaches the RAM while in reset.
  always_comb begin
    cpu_elig  = cpu_req & (state_q != ST_LOCKED) & ~i_rst;
    host_elig = host_req & ~i_rst;
    // On a tie the CPU wins only if the host had the previous grant.
    cpu_gnt   = cpu_elig & (~host_elig | (rr_last_q == RR_HOST));
    host_gnt  = host_elig & ~cpu_gnt;
  end

  // RAM port mux; with no grant the CPU bundle is passed through (don't-care).
  always_comb begin
    mem_en    = cpu_gnt | host_gnt;
    mem_we    = host_gnt ? host_we    : (cpu_gnt & cpu_we);
    mem_addr  = host_gnt ? host_addr  : cpu_addr;
    mem_wdata = host_gnt ? host_wdata : cpu_wdata;
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (host_gnt)     rr_last_d = RR_HOST;
    else if (cpu_gnt) rr_last_d = RR_CPU;
  end

  // PENDING waits until the CPU has neither a grant nor a read in flight,
  // so the lock never cuts off a response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: if (host_lock) state_d = ST_PENDING;
      ST_PENDING: begin
        if (!host_lock)                       state_d = ST_UNLOCKED;
        else if (!cpu_gnt && !cpu_rvalid_q)   state_d = ST_LOCKED;
      end
      ST_LOCKED:   if (!host_lock) state_d = ST_UNLOCKED;
      default:     state_d = ST_UNLOCKED;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (cpu_req && !cpu_gnt && !(&stall_q)) stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_UNLOCKED;
      rr_last_q     <= RR_HOST;
      locked_q      <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      locked_q      <= (state_d == ST_LOCKED);
      cpu_rvalid_q  <= cpu_gnt & ~cpu_we;
      host_rvalid_q <= host_gnt & ~host_we;
      stall_q       <= stall_d;
    end
  end

  assign locked      = locked_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign cpu_rdata   = mem_rdata;
  assign host_rdata  = mem_rdata;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_hrm_mem_arbiter.sv
// Directed bench for hrm_mem_arbiter. A second instance with a 4-bit stall
// counter shares the stimulus to observe saturation.
module tb_hrm_mem_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic i_rst;
  logic cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [AW-1:0] cpu_addr, host_addr;
  logic [DW-1:0] cpu_wdata, host_wdata;

  logic cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, locked;
  logic [DW-1:0] cpu_rdata, host_rdata;
  logic [15:0] stall_cnt;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic cpu_gnt4, cpu_rvalid4, host_gnt4, host_rvalid4, locked4;
  logic [DW-1:0] cpu_rdata4, host_rdata4;
  logic [3:0] stall_cnt4;
  logic mem_en4, mem_we4;
  logic [AW-1:0] mem_addr4;
  logic [DW-1:0] mem_wdata4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hrm_mem_arbiter #(.AW(AW), .DW(DW), .STALL_W(16)) u_dut (
    .clk(clk), .i_rst(i_rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_lock(host_lock), .locked(locked), .stall_cnt(stall_cnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  hrm_mem_arbiter #(.AW(AW), .DW(DW), .STALL_W(4)) u_dut4 (
    .clk(clk), .i_rst(i_rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt4), .cpu_rvalid(cpu_rvalid4), .cpu_rdata(cpu_rdata4),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt4), .host_rvalid(host_rvalid4), .host_rdata(host_rdata4),
    .host_lock(host_lock), .locked(locked4), .stall_cnt(stall_cnt4),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata)
  );

  // 32x8 synchronous RAM, 1-cycle read latency, driven by the main instance.
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    #1;
    chk("preload_gnt", host_gnt, 1);
    tick();
    host_req = 1'b0; host_we = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; host_lock = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    #3;
    // Reset state, with both requests asserted.
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_stall", stall_cnt, 0);
    cpu_req = 1'b0; host_req = 1'b0;
    tick();
    i_rst = 1'b0;

    host_write(5'd1, 8'h11);
    host_write(5'd2, 8'h22);
    host_write(5'd5, 8'h2A);
    rst_pulse();

    // CPU-only read of addr 5.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
    #1;
    chk("t1_cpu_gnt", cpu_gnt, 1);
    chk("t1_host_gnt", host_gnt, 0);
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_mem_addr", mem_addr, 5);
    tick();
    cpu_req = 1'b0;
    #1;
    chk("t1_cpu_rvalid", cpu_rvalid, 1);
    chk("t1_cpu_rdata", cpu_rdata, 8'h2A);
    chk("t1_host_rvalid", host_rvalid, 0);
    tick();
    chk("t1_rvalid_drop", cpu_rvalid, 0);

    // Simultaneous reads after reset: CPU wins first, then alternate.
    rst_pulse();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'd2;
    #1;
    chk("t2_gnt0_cpu", cpu_gnt, 1);
    chk("t2_gnt0_host", host_gnt, 0);
    tick();
    chk("t2_gnt1_cpu", cpu_gnt, 0);
    chk("t2_gnt1_host", host_gnt, 1);
    chk("t2_rv1_cpu", cpu_rvalid, 1);
    chk("t2_rd1", cpu_rdata, 8'h11);
    chk("t2_rv1_host", host_rvalid, 0);
    tick();
    chk("t2_gnt2_cpu", cpu_gnt, 1);
    chk("t2_gnt2_host", host_gnt, 0);
    chk("t2_rv2_host", host_rvalid, 1);
    chk("t2_rd2", host_rdata, 8'h22);
    chk("t2_rv2_cpu", cpu_rvalid, 0);
    tick();
    chk("t2_gnt3_cpu", cpu_gnt, 0);
    chk("t2_gnt3_host", host_gnt, 1);
    chk("t2_rv3_cpu", cpu_rvalid, 1);
    chk("t2_rd3", cpu_rdata, 8'h11);
    tick();
    cpu_req = 1'b0; host_req = 1'b0;
    #1;
    chk("t2_rv4_host", host_rvalid, 1);
    chk("t2_rd4", host_rdata, 8'h22);
    chk("t2_rv4_cpu", cpu_rvalid, 0);
    chk("t2_stall", stall_cnt, 2);

    // Host write 0x7F to addr 31, then CPU reads it back.
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 5'd31; host_wdata = 8'h7F;
    #1;
    chk("t3_host_gnt", host_gnt, 1);
    chk("t3_mem_we", mem_we, 1);
    chk("t3_mem_addr", mem_addr, 31);
    chk("t3_mem_wdata", mem_wdata, 8'h7F);
    tick();
    host_req = 1'b0; host_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd31;
    #1;
    chk("t3_cpu_gnt", cpu_gnt, 1);
    chk("t3_mem_we_rd", mem_we, 0);
    tick();
    cpu_req = 1'b0;
    #1;
    chk("t3_cpu_rvalid", cpu_rvalid, 1);
    chk("t3_cpu_rdata", cpu_rdata, 8'h7F);
    chk("t3_host_rvalid", host_rvalid, 0);

    // Lock sequence.
    rst_pulse();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
    #1;
    chk("t4_l0_gnt", cpu_gnt, 1);
    tick();
    host_lock = 1'b1;
    #1;
    chk("t4_l1_gnt", cpu_gnt, 1);
    chk("t4_l1_rv", cpu_rvalid, 1);
    tick();
    cpu_req = 1'b0;
    #1;
    chk("t4_l2_rv", cpu_rvalid, 1);
    chk("t4_l2_rd", cpu_rdata, 8'h2A);
    chk("t4_l2_locked", locked, 0);
    tick();
    chk("t4_l3_rv", cpu_rvalid, 0);
    chk("t4_l3_locked", locked, 0);
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3;
    host_req = 1'b1; host_we = 1'b1; host_addr = 5'd3; host_wdata = 8'h55;
    #1;
    chk("t4_l4_locked", locked, 1);
    chk("t4_l4_cpu_gnt", cpu_gnt, 0);
    chk("t4_l4_host_gnt", host_gnt, 1);
    chk("t4_l4_mem_we", mem_we, 1);
    chk("t4_l4_mem_addr", mem_addr, 3);
    tick();
    host_req = 1'b0; host_we = 1'b0;
    #1;
    chk("t4_l5_cpu_gnt", cpu_gnt, 0);
    tick();
    host_lock = 1'b0;
    #1;
    chk("t4_l6_cpu_gnt", cpu_gnt, 0);
    chk("t4_l6_locked", locked, 1);
    tick();
    chk("t4_l7_locked", locked, 0);
    chk("t4_l7_cpu_gnt", cpu_gnt, 1);
    chk("t4_l7_stall", stall_cnt, 3);
    tick();
    cpu_req = 1'b0;
    #1;
    chk("t4_l8_rv", cpu_rvalid, 1);
    chk("t4_l8_rd", cpu_rdata, 8'h55);

    // Stall saturation: stall is 3 here; 20 more locked cycles.
    host_lock = 1'b1;
    tick();
    tick();
    chk("t5_locked", locked, 1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
    #1;
    chk("t5_cpu_gnt", cpu_gnt, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("t5_stall16", stall_cnt, 23);
    chk("t5_stall4_sat", stall_cnt4, 15);
    host_lock = 1'b0;
    tick();
    chk("t5_unlock_gnt", cpu_gnt, 1);
    chk("t5_stall16_b", stall_cnt, 24);
    chk("t5_stall4_b", stall_cnt4, 15);

    // Async reset between grant and rvalid (rr_last is CPU here).
    tick();
    chk("t6_rv_before", cpu_rvalid, 1);
    i_rst = 1'b1;
    #1;
    chk("t6_rv_cpu", cpu_rvalid, 0);
    chk("t6_rv_host", host_rvalid, 0);
    chk("t6_locked", locked, 0);
    chk("t6_stall", stall_cnt, 0);
    chk("t6_gnt", cpu_gnt, 0);
    chk("t6_mem_en", mem_en, 0);
    tick();
    i_rst = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'd2;
    #1;
    chk("t6_tie_cpu", cpu_gnt, 1);
    chk("t6_tie_host", host_gnt, 0);
    tick();
    cpu_req = 1'b0;
    #1;
    chk("t6_rv_cpu_after", cpu_rvalid, 1);
    chk("t6_rd_after", cpu_rdata, 8'h2A);
    chk("t6_host_gnt2", host_gnt, 1);
    tick();
    host_req = 1'b0;
    #1;
    chk("t6_rv_host_after", host_rvalid, 1);
    chk("t6_rd_host_after", host_rdata, 8'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
